alu_op_sequencer: RTL

//  Issue side of the combinational ALU datapath: accepts one instruction word, reads two operands

---
 rtl/alu_op_sequencer_if.sv | 40 ++++
 rtl/alu_op_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer_if
// Purpose  : Decode/regfile/ALU bundle seen by the ALU issue sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface alu_op_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 4
);
    logic              ir_valid;
    logic              ir_ready;
    logic [31:0]       ir;
    logic [RA_W-1:0]   rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [31:0]       alu_op;
    logic [DATA_W-1:0] alu_c;
    logic              wb_en;
    logic [RA_W-1:0]   wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              busy;
    logic              illegal;

    // Sequencer side
    modport slave (
        input  ir_valid, ir, rf_rdata, alu_c,
        output ir_ready, rf_raddr, alu_a, alu_b, alu_op,
               wb_en, wb_addr, wb_data, busy, illegal
    );

    // Decode / regfile / ALU side
    modport master (
        output ir_valid, ir, rf_rdata, alu_c,
        input  ir_ready, rf_raddr, alu_a, alu_b, alu_op,
               wb_en, wb_addr, wb_data, busy, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Multi-cycle issue sequencer: operand fetch over one regfile read
//            port, ALU drive, result capture and writeback. Optional macro
//            ALU_SEQ_R0_ZERO_EN makes register 0 read as zero and ignore writes.
// Revision : 1.0  initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 4
) (
    input  logic                clock_i,
    input  logic                clear_i,
    alu_op_sequencer_if.slave   bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_LOAD_Y = 3'd2;
    localparam logic [2:0] S_LOAD_B = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SHR = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b00111;
    localparam logic [4:0] OP_AND = 5'b01010;
    localparam logic [4:0] OP_OR  = 5'b01011;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_NEG = 5'b10001;
    localparam logic [4:0] OP_NOT = 5'b10010;

    logic [2:0]        state_q, state_d;
    logic [31:0]       ir_q;
    logic [DATA_W-1:0] y_q, b_q, z_q;

    logic [4:0]        opcode;
    logic [RA_W-1:0]   ra, rb, rc;
    logic              supported, unary;
    logic [RA_W-1:0]   raddr;
    logic [DATA_W-1:0] rdata_eff;
    logic              wb_allow;

    assign opcode = ir_q[31:27];
    assign ra     = RA_W'(ir_q[26:23]);
    assign rb     = RA_W'(ir_q[22:19]);
    assign rc     = RA_W'(ir_q[18:15]);
    assign unary  = (opcode == OP_NEG) || (opcode == OP_NOT);

    always_comb begin
        supported = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_AND,
            OP_OR, OP_MUL, OP_NEG, OP_NOT: supported = 1'b1;
            default:                       supported = 1'b0;
        endcase
    end

`ifdef ALU_SEQ_R0_ZERO_EN
    assign rdata_eff = (raddr == '0) ? '0 : bus.rf_rdata;
    assign wb_allow  = (ra != '0);
`else
    assign rdata_eff = bus.rf_rdata;
    assign wb_allow  = 1'b1;
`endif

    always_ff @(posedge clock_i or posedge clear_i) begin
        if (clear_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.ir_valid) state_d = S_DECODE;
            S_DECODE: state_d = supported ? S_LOAD_Y : S_IDLE;
            S_LOAD_Y: state_d = unary ? S_EXEC : S_LOAD_B;
            S_LOAD_B: state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ir_ready = 1'b0;
        bus.busy     = 1'b1;
        bus.illegal  = 1'b0;
        bus.wb_en    = 1'b0;
        raddr        = '0;
        case (state_q)
            S_IDLE: begin
                bus.ir_ready = 1'b1;
                bus.busy     = 1'b0;
            end
            S_DECODE: bus.illegal = ~supported;
            S_LOAD_Y: raddr       = rb;
            S_LOAD_B: raddr       = rc;
            S_WB:     bus.wb_en   = wb_allow;
            default: ;
        endcase
    end

    assign bus.rf_raddr = raddr;
    assign bus.alu_a    = y_q;
    assign bus.alu_b    = b_q;
    assign bus.alu_op   = ir_q;
    assign bus.wb_addr  = ra;
    assign bus.wb_data  = z_q;

    // Unary ops never visit LOAD_B, so B is zeroed while Y is fetched.
    always_ff @(posedge clock_i or posedge clear_i) begin
        if (clear_i) begin
            ir_q <= '0;
            y_q  <= '0;
            b_q  <= '0;
            z_q  <= '0;
        end else begin
            if (state_q == S_IDLE && bus.ir_valid) begin
                ir_q <= bus.ir;
            end
            if (state_q == S_LOAD_Y) begin
                y_q <= rdata_eff;
                if (unary) begin
                    b_q <= '0;
                end
            end
            if (state_q == S_LOAD_B) begin
                b_q <= rdata_eff;
            end
            if (state_q == S_EXEC) begin
                z_q <= bus.alu_c;
            end
        end
    end
endmodule
`default_nettype wire
